// File: rtl/rv32i_types.sv
// Types shared across the memory-side blocks. This file holds the arbiter
// state encoding and the default cacheline width.
package rv32i_types;

  localparam int LINE_W_DEF = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one shared
// memory port. D side has fixed priority.
//
// state   | meaning
// IDLE    | no transaction; pick D (read/write) over I (read)
// SERVE_I | I-side fill outstanding on memory, waiting for mem_resp
// SERVE_D | D-side fill or writeback outstanding, waiting for mem_resp
// RESP_I  | one-cycle i_resp pulse, i_rdata valid
// RESP_D  | one-cycle d_resp pulse, d_rdata valid
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       busy_cycles
);

  arb_state_e        state;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic [31:0]       busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= '0;
    end else begin
      if (state != IDLE && busy_q != 32'hFFFF_FFFF)
        busy_q <= busy_q + 32'd1;

      case (state)
        IDLE: begin
          // A simultaneous read+write from D is serviced as the writeback.
          if (d_read || d_write) begin
            state   <= SERVE_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            op_wr   <= d_write;
          end else if (i_read) begin
            state  <= SERVE_I;
            addr_q <= i_addr;
            op_wr  <= 1'b0;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            i_rdata_q <= mem_rdata;
            state     <= RESP_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            // A writeback returns no line, so d_rdata keeps the last fill.
            if (!op_wr)
              d_rdata_q <= mem_rdata;
            state <= RESP_D;
          end
        end
        RESP_I, RESP_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // Strobes decode from registered state/op only, so they cannot glitch.
  assign mem_read    = (state == SERVE_I) || (state == SERVE_D && !op_wr);
  assign mem_write   = (state == SERVE_D) && op_wr;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_resp      = (state == RESP_I);
  assign d_resp      = (state == RESP_D);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: expected responses are queued when
// a request is driven and compared when the arbiter pulses i_resp/d_resp.
module tb_cache_arbiter;
  import rv32i_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   busy_cycles;

  typedef struct {
    logic          side_d;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [LW-1:0] last_i, last_d;
  logic [31:0]   b0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic push_exp(input logic side_d, input logic [LW-1:0] data);
    exp_t e;
    e.side_d = side_d;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (i_resp || d_resp)) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {i_resp, d_resp}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_side", {i_resp, d_resp}, mon_e.side_d ? 2'b01 : 2'b10);
        chk("resp_data", mon_e.side_d ? d_rdata : i_rdata, mon_e.data);
      end
    end
  end

  // Memory model: waits for a strobe, checks the request each cycle it is
  // held, answers on the lat-th cycle, and expects the strobe to drop after.
  task automatic mem_txn(input int lat, input logic [LW-1:0] rdata, input logic [AW-1:0] exp_addr,
                         input logic exp_wr, input logic [LW-1:0] exp_wdata);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("strobe_timeout", 0, 1);
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      chk("mem_op", {mem_read, mem_write}, exp_wr ? 2'b01 : 2'b10);
      chk("mem_addr", mem_addr, exp_addr);
      if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
      if (k == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_resp = 1'b0;
    chk("strobe_low", {mem_read, mem_write}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] pa, pb, pc, pd, pi, pe, junk;
    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    last_i = '0; last_d = '0;
    repeat (2) @(negedge clk);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy_cycles, 0);
    rst = 1'b1;
    @(negedge clk);

    // I-side fill, memory answers on the third cycle of the request
    pa = rnd_line();
    i_read = 1; i_addr = 32'h60;
    push_exp(1'b0, pa); last_i = pa;
    @(negedge clk);
    i_read = 0;
    mem_txn(3, pa, 32'h60, 1'b0, '0);
    @(negedge clk);

    // Simultaneous I and D reads: D first, one idle bubble, then I
    pd = rnd_line(); pi = rnd_line();
    b0 = busy_cycles;
    d_read = 1; d_addr = 32'h100; i_read = 1; i_addr = 32'h200;
    push_exp(1'b1, pd); push_exp(1'b0, pi);
    @(negedge clk);
    d_read = 0;
    mem_txn(1, pd, 32'h100, 1'b0, '0);
    last_d = pd;
    @(negedge clk);
    chk("bubble_strobes", {mem_read, mem_write}, 0);
    @(negedge clk);
    i_read = 0;
    mem_txn(2, pi, 32'h200, 1'b0, '0);
    last_i = pi;
    @(negedge clk);
    chk("busy_two_txn", busy_cycles, b0 + 32'd5);

    // Writeback: d_rdata must keep the last fill
    pb = rnd_line(); junk = rnd_line();
    d_write = 1; d_addr = 32'h80; d_wdata = pb;
    push_exp(1'b1, last_d);
    @(negedge clk);
    d_write = 0;
    mem_txn(2, junk, 32'h80, 1'b1, pb);
    @(negedge clk);

    // Read and write together: serviced as a write
    pc = rnd_line(); junk = rnd_line();
    d_read = 1; d_write = 1; d_addr = 32'h90; d_wdata = pc;
    push_exp(1'b1, last_d);
    @(negedge clk);
    d_read = 0; d_write = 0;
    mem_txn(1, junk, 32'h90, 1'b1, pc);
    @(negedge clk);

    // Spurious mem_resp while idle is ignored
    b0 = busy_cycles;
    mem_resp = 1; mem_rdata = rnd_line();
    @(negedge clk);
    mem_resp = 0;
    chk("spur_strobes", {mem_read, mem_write}, 0);
    chk("spur_i_rdata", i_rdata, last_i);
    chk("spur_d_rdata", d_rdata, last_d);
    @(negedge clk);
    chk("spur_busy", busy_cycles, b0);

    // I request withdrawn during SERVE_I still completes
    pi = rnd_line();
    i_read = 1; i_addr = 32'h44;
    push_exp(1'b0, pi);
    @(negedge clk);
    i_read = 0;
    @(negedge clk);
    mem_txn(2, pi, 32'h44, 1'b0, '0);
    last_i = pi;
    @(negedge clk);

    // Reset during SERVE_D: strobes drop at once, no response pulse
    d_read = 1; d_addr = 32'h300;
    @(negedge clk);
    chk("pre_rst_read", mem_read, 1);
    d_read = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_strobes", {mem_read, mem_write}, 0);
    chk("async_busy", busy_cycles, 0);
    chk("async_d_rdata", d_rdata, 0);
    chk("async_i_rdata", i_rdata, 0);
    chk("async_resp", {i_resp, d_resp}, 0);
    last_i = '0; last_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {mem_read, mem_write, d_resp}, 0);
    pe = rnd_line();
    d_read = 1; d_addr = 32'h340;
    push_exp(1'b1, pe);
    @(negedge clk);
    d_read = 0;
    mem_txn(1, pe, 32'h340, 1'b0, '0);
    last_d = pe;
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
